// File: rtl/conv_bias_loader_if.sv
// Byte-stream intake and SRAM write-port bundle for the conv bias loader.
// master = host/config side, slave = loader side.
interface conv_bias_loader_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;
    logic              mem_me;

    modport master (
        output in_valid, in_byte,
        input  in_ready, mem_adr, mem_d, mem_we, mem_me
    );

    modport slave (
        input  in_valid, in_byte,
        output in_ready, mem_adr, mem_d, mem_we, mem_me
    );
endinterface

// File: rtl/conv_bias_loader.sv
// Packs a little-endian byte stream into bias words and writes them to
// SRAM addresses 0..NUM_BIAS-1, holding busy while the macro is in use.
module conv_bias_loader #(
    parameter int unsigned NUM_BIAS = 11,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    conv_bias_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int unsigned     BYTES    = DATA_W / 8;
    localparam int unsigned     IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [ADDR_W:0]  CNT_FULL = (ADDR_W + 1)'(NUM_BIAS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state,    w_state_nxt;
    logic [IDX_W-1:0]  r_idx,      w_idx_nxt;
    logic [DATA_W-1:0] r_word,     w_word_nxt;
    logic [ADDR_W:0]   r_word_cnt, w_word_cnt_nxt;
    logic              r_in_ready, w_in_ready_nxt;
    logic [ADDR_W-1:0] r_mem_adr,  w_mem_adr_nxt;
    logic [DATA_W-1:0] r_mem_d,    w_mem_d_nxt;
    logic              r_mem_we,   w_mem_we_nxt;
    logic              r_mem_me,   w_mem_me_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_done,     w_done_nxt;

    logic              w_hs;
    logic [ADDR_W:0]   w_cnt_inc;

    assign w_hs      = bus.in_valid & r_in_ready;
    assign w_cnt_inc = r_word_cnt + (ADDR_W + 1)'(1);

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_word_nxt     = r_word;
        w_word_cnt_nxt = r_word_cnt;
        w_mem_adr_nxt  = r_mem_adr;
        w_mem_d_nxt    = r_mem_d;
        w_mem_we_nxt   = 1'b0;
        w_mem_me_nxt   = 1'b0;
        w_done_nxt     = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt    = S_COLLECT;
                    w_word_cnt_nxt = '0;
                    w_idx_nxt      = '0;
                    w_word_nxt     = '0;
                end
            end
            S_COLLECT: begin
                if (w_hs) begin
                    w_word_nxt[{r_idx, 3'b000} +: 8] = bus.in_byte;
                    if (r_idx == LAST_IDX) begin
                        w_idx_nxt     = '0;
                        w_state_nxt   = S_WRITE;
                        w_mem_we_nxt  = 1'b1;
                        w_mem_me_nxt  = 1'b1;
                        w_mem_adr_nxt = r_word_cnt[ADDR_W-1:0];
                        w_mem_d_nxt   = w_word_nxt;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            S_WRITE: begin
                w_word_cnt_nxt = w_cnt_inc;
                if (w_cnt_inc == CNT_FULL) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_COLLECT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_in_ready_nxt = (w_state_nxt == S_COLLECT);
        w_busy_nxt     = (w_state_nxt == S_COLLECT) || (w_state_nxt == S_WRITE);
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_word     <= '0;
            r_word_cnt <= '0;
            r_in_ready <= 1'b0;
            r_mem_adr  <= '0;
            r_mem_d    <= '0;
            r_mem_we   <= 1'b0;
            r_mem_me   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_word     <= w_word_nxt;
            r_word_cnt <= w_word_cnt_nxt;
            r_in_ready <= w_in_ready_nxt;
            r_mem_adr  <= w_mem_adr_nxt;
            r_mem_d    <= w_mem_d_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_mem_me   <= w_mem_me_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.mem_adr  = r_mem_adr;
    assign bus.mem_d    = r_mem_d;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_me   = r_mem_me;
    assign busy         = r_busy;
    assign done         = r_done;
    assign word_cnt     = r_word_cnt;

endmodule

// File: tb/tb_conv_bias_loader.sv
// Directed/randomized bench for conv_bias_loader: byte streams are packed by a
// reference model into expected (address, word) writes and compared to the SRAM port.
module tb_conv_bias_loader;

    localparam int unsigned NUM_BIAS = 11;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            start;
    logic            busy;
    logic            done;
    logic [ADDR_W:0] word_cnt;

    conv_bias_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    conv_bias_loader #(
        .NUM_BIAS (NUM_BIAS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .start    (start),
        .bus      (bus.slave),
        .busy     (busy),
        .done     (done),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;
    int t_start  = 0;
    int bad_we   = 0;

    logic [7:0]        tx[$];
    logic [ADDR_W-1:0] got_adr[$];
    logic [DATA_W-1:0] got_d[$];

    // Write-port observer: records every write, flags illegal port combinations.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            got_adr.push_back(bus.mem_adr);
            got_d.push_back(bus.mem_d);
            if (bus.in_ready !== 1'b0 || bus.mem_me !== 1'b1) bad_we++;
        end else if (bus.mem_me !== 1'b0) begin
            bad_we++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: bias word k is bytes 4k..4k+3 of the stream, least significant first.
    function automatic logic [DATA_W-1:0] model_word(input int k);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int b = 0; b < 4; b++)
            w = w + (DATA_W'(tx[4*k+b]) << (8*b));
        return w;
    endfunction

    task automatic make_tx(input int kind);
        logic [DATA_W-1:0] w;
        tx.delete();
        for (int k = 0; k < NUM_BIAS; k++) begin
            if (kind == 0) w = DATA_W'(32'h1000_0000 + k);
            else           w = DATA_W'($urandom);
            if (kind == 1 && k == 0) begin
                tx.push_back(8'hEF); tx.push_back(8'hBE);
                tx.push_back(8'hAD); tx.push_back(8'hDE);
            end else begin
                for (int b = 0; b < 4; b++) tx.push_back(8'(w >> (8*b)));
            end
        end
    endtask

    task automatic clear_got();
        got_adr.delete();
        got_d.delete();
    endtask

    task automatic check_writes(input string tag, input int n_words);
        chk($sformatf("%s_nwrites", tag), 64'(got_adr.size()), 64'(n_words));
        for (int k = 0; k < n_words; k++) begin
            if (k < got_adr.size()) begin
                chk($sformatf("%s_adr%0d", tag, k), 64'(got_adr[k]), 64'(k));
                chk($sformatf("%s_data%0d", tag, k), 64'(got_d[k]), 64'(model_word(k)));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk($sformatf("%s_in_ready", tag), 64'(bus.in_ready), 64'(0));
        chk($sformatf("%s_mem_we", tag),   64'(bus.mem_we),   64'(0));
        chk($sformatf("%s_mem_me", tag),   64'(bus.mem_me),   64'(0));
        chk($sformatf("%s_mem_adr", tag),  64'(bus.mem_adr),  64'(0));
        chk($sformatf("%s_mem_d", tag),    64'(bus.mem_d),    64'(0));
        chk($sformatf("%s_busy", tag),     64'(busy),         64'(0));
        chk($sformatf("%s_done", tag),     64'(done),         64'(0));
        chk($sformatf("%s_word_cnt", tag), 64'(word_cnt),     64'(0));
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic do_start();
        start   = 1'b1;
        t_start = cyc;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Feeds tx; valid is held once raised until accepted. Optional one-cycle start pulse.
    task automatic stream(input int pct, input int start_at);
        int   i       = 0;
        int   guard   = 0;
        logic hold    = 1'b0;
        logic fired   = 1'b0;
        logic bubbled = 1'b0;
        while (i < tx.size() && guard < 5000) begin
            if (!hold) begin
                bus.in_valid = ($urandom_range(99) < pct);
                if (pct < 100 && i == 2 && !bubbled) begin
                    bus.in_valid = 1'b0;
                    bubbled      = 1'b1;
                end
            end
            bus.in_byte = tx[i];
            start = (i == start_at) && !fired;
            if (start) fired = 1'b1;
            hold = bus.in_valid && !bus.in_ready;
            if (bus.in_valid && bus.in_ready) i++;
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        start        = 1'b0;
        chk("stream_complete", 64'(i), 64'(tx.size()));
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_done_seen", tag), 64'(done), 64'(1));
        if (exp_lat > 0)
            chk($sformatf("%s_done_latency", tag), 64'(cyc - t_start), 64'(exp_lat));
        chk($sformatf("%s_busy_at_done", tag), 64'(busy), 64'(0));
        chk($sformatf("%s_cnt_at_done", tag), 64'(word_cnt), 64'(NUM_BIAS));
        chk($sformatf("%s_ready_at_done", tag), 64'(bus.in_ready), 64'(0));
        @(negedge clk);
        chk($sformatf("%s_done_pulse", tag), 64'(done), 64'(0));
        chk($sformatf("%s_busy_after", tag), 64'(busy), 64'(0));
    endtask

    initial begin
        rst_b        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        check_zero("reset");

        // Valid bytes offered in IDLE without start must not be consumed.
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h55;
        repeat (5) @(negedge clk);
        chk("idle_in_ready", 64'(bus.in_ready), 64'(0));
        chk("idle_writes", 64'(got_adr.size()), 64'(0));
        chk("idle_word_cnt", 64'(word_cnt), 64'(0));
        bus.in_valid = 1'b0;

        // Full-rate load of the 0x1000_000k pattern.
        make_tx(0);
        clear_got();
        do_start();
        chk("t1_busy_after_start", 64'(busy), 64'(1));
        chk("t1_cnt_after_start", 64'(word_cnt), 64'(0));
        stream(100, -1);
        chk("t1_busy_last_write", 64'(busy), 64'(1));
        chk("t1_we_last_write", 64'(bus.mem_we), 64'(1));
        wait_done("t1", 56);
        check_writes("t1", NUM_BIAS);

        // Reload from DONE, random valid gaps, stray start mid-load.
        clear_got();
        do_start();
        chk("t2_cnt_reload", 64'(word_cnt), 64'(0));
        stream(60, 17);
        wait_done("t2", -1);
        check_writes("t2", NUM_BIAS);

        // Negative bias in word 0, random remaining words.
        make_tx(1);
        clear_got();
        do_start();
        stream(100, -1);
        wait_done("t3", 56);
        check_writes("t3", NUM_BIAS);
        if (got_d.size() > 0) chk("t3_deadbeef", 64'(got_d[0]), 64'(32'hDEADBEEF));

        // Reset after two words plus two bytes: partial word is dropped.
        make_tx(2);
        tx = tx[0:9];
        clear_got();
        do_start();
        stream(70, -1);
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        check_zero("midrst");
        check_writes("t4_partial", 2);

        make_tx(2);
        clear_got();
        do_start();
        stream(100, -1);
        wait_done("t4", 56);
        check_writes("t4", NUM_BIAS);

        chk("we_protocol", 64'(bad_we), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_bias_loader.md
Name: conv_bias_loader

Overview:
- Write-side companion of the conv-layer bias SRAM read path.
- Accepts a byte stream from the host/config interface over a valid/ready handshake and packs each group of 4 bytes, little-endian, into a 32-bit signed bias word.
- Writes the words to consecutive SRAM addresses 0..NUM_BIAS-1 through the macro's write port (ADR/D/WE/ME).
- Holds `busy` high while loading so the conv read path is kept off the macro, and pulses `done` when finished.

Parameters:
- NUM_BIAS, 11, number of bias words to load (1..2^ADDR_W).
- ADDR_W, 5, SRAM address width.
- DATA_W, 32, bias word width; must be a multiple of 8.

Ports:
- clk  in  1  clock; one clock domain.
- rst_b  in  1  reset; synchronous and active-high (the reset is asserted when rst_b=1).
- start  in  1  1-cycle pulse; begins a load. Honoured only in IDLE or DONE.
- in_valid  in  1  in_byte is valid.
- in_byte  in  8  next bias byte, LSB-first within each word.
- in_ready  out  1  loader accepts in_byte this cycle.
- mem_adr  out  ADDR_W  SRAM address.
- mem_d  out  DATA_W  SRAM write data.
- mem_we  out  1  SRAM write enable.
- mem_me  out  1  SRAM memory enable.
- busy  out  1  high from start accept until the final write completes.
- done  out  1  1-cycle pulse after the final write.
- word_cnt  out  ADDR_W+1  number of words written so far.

Behaviour:
- Reset (rst_b=1 at a clk edge) puts the block in IDLE and clears every output and internal register: in_ready, mem_we, mem_me, busy and done =0; mem_adr, mem_d and word_cnt =0; byte index =0; word register =0.
- Reset mid-load discards any partial word. Words already written stay in the SRAM and are not rewritten.
- States:
  - IDLE: in_ready=0. When start=1, clear word_cnt and go to COLLECT; busy=1 from the next cycle.
  - COLLECT: in_ready=1. On each handshake (in_valid & in_ready), place the byte at bits [8*idx+7:8*idx] of the word register and increment idx. When the handshake takes idx from 3 to 0 (byte 4 accepted), go to WRITE on the next edge.
  - WRITE: lasts exactly 1 cycle.
    - in_ready=0.
    - mem_we=1, mem_me=1, mem_adr=word_cnt[ADDR_W-1:0], mem_d=assembled word.
    - At the end of the cycle word_cnt increments.
    - If the new word_cnt == NUM_BIAS, go to DONE; otherwise go to COLLECT.
  - DONE: done=1 for the first cycle only; busy=0; in_ready=0. A start pulse returns to COLLECT with word_cnt=0 (reload). Otherwise stay in DONE.
- Outputs mem_we, mem_me, mem_adr, mem_d and in_ready are registered; nothing combinational passes from input to output.
- Whenever mem_we=0: mem_me=0 and mem_d holds its last value.
- start is ignored in COLLECT and WRITE.
- in_valid while in_ready=0: the byte is not consumed and must be held by upstream under the standard valid/ready rule.
- Latency: the 4th byte handshake at cycle N produces the write at cycle N+1. For NUM_BIAS=11 with in_valid continuously high, the minimum load time is 11*(4+1)=55 cycles after start; done asserts at cycle 56 after start.
- Byte index wraps 3→0; word_cnt never exceeds NUM_BIAS.
- word_cnt must fit NUM_BIAS=2^ADDR_W, which is why it is ADDR_W+1 bits wide.

Test Plan:
- Reset then start; stream 44 bytes (word k = 32'h1000_0000+k, LSB first) with in_valid held 1 -> 11 writes at adr 0..10 with mem_d=32'h1000_0000..32'h1000_000A; mem_we high exactly 11 cycles; done pulses 1 cycle, 56 cycles after start; busy falls with done.
- Same stream with in_valid toggled randomly, plus a bubble inside a word -> identical write sequence; no duplicated or dropped bytes; in_ready=0 during each WRITE cycle.
- Bytes 8'hEF, 8'hBE, 8'hAD, 8'hDE for word 0 -> mem_d=32'hDEADBEEF (negative bias) at adr 0.
- Assert reset after 2 words plus 2 bytes -> all outputs 0 next cycle and state IDLE. A new start followed by 44 bytes writes from adr 0; the partial word is never written.
- start pulsed mid-load -> ignored, word_cnt unaffected. start pulsed in DONE -> reload from adr 0; second done after 11 more writes.
- in_valid=1 while in IDLE without start -> in_ready=0, no bytes consumed, mem_we=0.
